axis_mux_inject: RTL and testbench
==================================

# axis_mux_inject

Multi-channel AXI-Stream injection mux for the NoC endpoint. It merges NUM_CHANNELS independent single-clock AXIS sources onto one router input port using the send/credit/is_tail flit protocol. Arbitration is round-robin with wormhole packet locking, and flow control is credit-based against the router's input flit buffer. It is the generalisation of the single-channel injection path, for tiles that expose several user streams to one router local port.

## Interface
Parameters:
- NUM_CHANNELS, 4: number of AXIS input channels (≥1)
- TDATA_WIDTH, 128: AXIS data width = flit width (no serialization)
- TID_WIDTH, 2: AXIS tid width
- TDEST_WIDTH, 4: AXIS tdest width
- DEST_WIDTH, TID_WIDTH+TDEST_WIDTH: flit dest width
- FLIT_BUFFER_DEPTH, 4: router input buffer depth = initial credits (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk_noc  in  1  NoC clock
- rst_noc_sync  in  1  synchronous active-high reset
- axis_in_tvalid  in  [NUM_CHANNELS]  per-channel valid
- axis_in_tready  out  [NUM_CHANNELS]  per-channel ready
- axis_in_tdata  in  [NUM_CHANNELS][TDATA_WIDTH]  data
- axis_in_tlast  in  [NUM_CHANNELS]  end of packet
- axis_in_tid  in  [NUM_CHANNELS][TID_WIDTH]  id
- axis_in_tdest  in  [NUM_CHANNELS][TDEST_WIDTH]  destination
- data_out  out  TDATA_WIDTH  flit data
- dest_out  out  DEST_WIDTH  {tid, tdest}
- is_tail_out  out  1  flit is last of packet
- send_out  out  1  flit valid, one cycle per flit
- credit_in  in  1  one credit returned per pulse

## Operation
- Credit counter width is $clog2(FLIT_BUFFER_DEPTH+1). Reset value is FLIT_BUFFER_DEPTH. Each cycle: next = count − xfer + credit_in.
- A transfer (xfer) is allowed only when count > 0 at cycle start. A credit arriving in the same cycle is usable next cycle.
- credit_in while count == FLIT_BUFFER_DEPTH and no xfer is a protocol error. It is flagged by an assertion and the counter saturates.
- Arbiter FSM states:
  - IDLE: grant is round-robin over asserted tvalid, starting at rr_ptr.
  - LOCKED(owner): grant is forced to owner, regardless of other valids.
- axis_in_tready[i] = grant[i] && count > 0. At most one tready is high per cycle. tready may depend combinationally on tvalid in IDLE.
- Handshake on channel i with tlast=0 in IDLE: go to LOCKED(i).
- Handshake with tlast=1 in either state: go to IDLE, rr_ptr = (i+1) mod NUM_CHANNELS.
- Single-flit packets never enter LOCKED.
- In LOCKED with owner tvalid low: no transfer occurs, and other channels stay blocked (wormhole).
- NUM_CHANNELS=1 degenerates to a credit-gated pass-through with a 1-cycle register.

## Timing
- Output stage is fully registered. A handshake in cycle N gives send_out=1 in N+1, with data_out, dest_out and is_tail_out carrying that flit.
- send_out is 0 in cycles with no handshake. Data outputs hold their last value.
- Throughput is 1 flit/cycle while credits are available.
- Round-trip stall: with FLIT_BUFFER_DEPTH credits and return latency L, full rate needs depth ≥ L+1.
- Reset values: send_out=0, is_tail_out=0, data_out=0, dest_out=0, axis_in_tready=0 during reset, count=FLIT_BUFFER_DEPTH, state=IDLE, rr_ptr=0.
- Reset mid-packet: the lock is dropped and credits are restored. The router and sources are reset on the same domain reset.

## Configuration
- AXIS_MUX_INJECT_STATS_EN defined:
  - Adds output port pkt_count out [NUM_CHANNELS][32], one counter per channel.
  - A counter increments on each tlast handshake of its channel and wraps at 2^32.
  - Reset value is 0.
- Macro undefined: the port and counters are absent. Flit behaviour is identical.

## Structure
- Shared package axis_mux_inject_pkg holds:
  - the arb_state_t enum {IDLE, LOCKED};
  - the credit-width localparam function.
- Sub-module rr_arbiter (NUM_REQ parameter) provides request vector, rr_ptr, one-hot grant and grant index. It is purely combinational; the FSM and pointer live in the top.

## Test plan
- Credit exhaustion: after reset, channel 0 streams 6 single-flit packets with credit_in held 0. Expect exactly 4 send_out pulses, then tready low. One credit_in pulse releases exactly 1 more flit.
- Round-robin: all 4 channels hold single-flit packets with infinite credits. Grant order is 0,1,2,3,0; dest_out matches each channel's {tid, tdest}.
- Wormhole lock: channel 1 sends a 3-flit packet while channel 2 is valid. Channel 2 receives no tready until channel 1's tlast handshake. is_tail_out is high only on the 3rd flit, and channel 2 follows on the next cycle.
- Owner bubble: channel 0 drops tvalid mid-packet for 2 cycles while channel 3 is valid. Expect no send_out for those 2 cycles and channel 3 still blocked.
- Reset mid-packet: assert rst_noc_sync after 1 of 4 flits. Next cycle send_out=0, credits=4, IDLE. A new packet from channel 2 is granted immediately.
- Stats (AXIS_MUX_INJECT_STATS_EN): 5 packets on channel 1 and 2 on channel 3 give pkt_count {0,5,0,2}.

Source files
------------

// File: rtl/axis_mux_inject_pkg.sv
//==============================================================================
// Module      : axis_mux_inject_pkg
// Description : Shared types and width helpers for the AXIS injection mux.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package axis_mux_inject_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Counter must hold the full depth, hence depth+1 values.
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/axis_mux_inject_rr_arbiter.sv
//==============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter, search starts at rr_ptr.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter
   import axis_mux_inject_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = index_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;
   logic             found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = 32'(rr_ptr) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found           = 1'b1;
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/axis_mux_inject.sv
//==============================================================================
// Module      : axis_mux_inject
// Description : Round-robin, wormhole-locked, credit-gated AXIS to flit mux.
//               Optional per-channel packet counters: AXIS_MUX_INJECT_STATS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axis_mux_inject
   import axis_mux_inject_pkg::*;
#(
   parameter int NUM_CHANNELS      = 4,
   parameter int TDATA_WIDTH       = 128,
   parameter int TID_WIDTH         = 2,
   parameter int TDEST_WIDTH       = 4,
   parameter int DEST_WIDTH        = TID_WIDTH + TDEST_WIDTH,
   parameter int FLIT_BUFFER_DEPTH = 4
) (
   input  logic                                      clk_noc,
   input  logic                                      rst_noc_sync,
   input  logic [NUM_CHANNELS-1:0]                   axis_in_tvalid,
   output logic [NUM_CHANNELS-1:0]                   axis_in_tready,
   input  logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0]  axis_in_tdata,
   input  logic [NUM_CHANNELS-1:0]                   axis_in_tlast,
   input  logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]    axis_in_tid,
   input  logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0]  axis_in_tdest,
   output logic [TDATA_WIDTH-1:0]                    data_out,
   output logic [DEST_WIDTH-1:0]                     dest_out,
   output logic                                      is_tail_out,
   output logic                                      send_out,
`ifdef AXIS_MUX_INJECT_STATS_EN
   output logic [NUM_CHANNELS-1:0][31:0]             pkt_count,
`endif
   input  logic                                      credit_in
);

   localparam int               CNT_W      = credit_width(FLIT_BUFFER_DEPTH);
   localparam int               IDX_W      = index_width(NUM_CHANNELS);
   localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(FLIT_BUFFER_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CHANNELS - 1);

   arb_state_t                state_q, state_d;
   logic [IDX_W-1:0]          owner_q, owner_d;
   logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]          count_q, count_d;

   logic                      send_q, send_d;
   logic                      tail_q, tail_d;
   logic [TDATA_WIDTH-1:0]    data_q, data_d;
   logic [DEST_WIDTH-1:0]     dest_q, dest_d;

   logic [NUM_CHANNELS-1:0]   arb_grant;
   logic [IDX_W-1:0]          arb_idx;
   logic [NUM_CHANNELS-1:0]   grant;
   logic [IDX_W-1:0]          grant_idx;
   logic                      credit_ok;
   logic                      xfer;
   logic                      xfer_last;

   rr_arbiter #(
      .NUM_REQ   (NUM_CHANNELS),
      .IDX_W     (IDX_W)
   ) u_rr_arbiter (
      .req       (axis_in_tvalid),
      .rr_ptr    (rr_ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   // FSM: state register
   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      if (xfer) begin
         if (axis_in_tlast[grant_idx]) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
         end else if (state_q == IDLE) begin
            state_d = LOCKED;
            owner_d = grant_idx;
         end
      end
   end

   // FSM: outputs. A locked owner keeps the grant even while its tvalid is low.
   always_comb begin
      grant     = arb_grant;
      grant_idx = arb_idx;
      if (state_q == LOCKED) begin
         grant          = '0;
         grant[owner_q] = 1'b1;
         grant_idx      = owner_q;
      end
   end

   assign credit_ok      = (count_q != '0) && !rst_noc_sync;
   assign axis_in_tready = credit_ok ? grant : '0;
   assign xfer           = |(axis_in_tvalid & axis_in_tready);
   assign xfer_last      = xfer && axis_in_tlast[grant_idx];

   // A credit returned while the counter is full is dropped (saturate).
   always_comb begin
      count_d = count_q;
      if (xfer && !credit_in) begin
         count_d = count_q - CNT_W'(1);
      end else if (!xfer && credit_in && (count_q != CREDIT_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_comb begin
      send_d = xfer;
      tail_d = tail_q;
      data_d = data_q;
      dest_d = dest_q;
      if (xfer) begin
         tail_d = axis_in_tlast[grant_idx];
         data_d = axis_in_tdata[grant_idx];
         dest_d = DEST_WIDTH'({axis_in_tid[grant_idx], axis_in_tdest[grant_idx]});
      end
   end

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         count_q <= CREDIT_MAX;
         send_q  <= 1'b0;
         tail_q  <= 1'b0;
         data_q  <= '0;
         dest_q  <= '0;
      end else begin
         count_q <= count_d;
         send_q  <= send_d;
         tail_q  <= tail_d;
         data_q  <= data_d;
         dest_q  <= dest_d;
      end
   end

   assign send_out    = send_q;
   assign is_tail_out = tail_q;
   assign data_out    = data_q;
   assign dest_out    = dest_q;

   credit_overflow_a: assert property (@(posedge clk_noc) disable iff (rst_noc_sync)
      !(credit_in && !xfer && (count_q == CREDIT_MAX)));

`ifdef AXIS_MUX_INJECT_STATS_EN
   logic [NUM_CHANNELS-1:0][31:0] pkt_count_q, pkt_count_d;

   always_comb begin
      pkt_count_d = pkt_count_q;
      if (xfer_last) begin
         pkt_count_d[grant_idx] = pkt_count_q[grant_idx] + 32'd1;
      end
   end

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         pkt_count_q <= '0;
      end else begin
         pkt_count_q <= pkt_count_d;
      end
   end

   assign pkt_count = pkt_count_q;
`else
   logic unused_xfer_last;
   assign unused_xfer_last = xfer_last;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_mux_inject.sv
//==============================================================================
// Module      : tb_axis_mux_inject
// Description : Scoreboard bench for axis_mux_inject (4 channels, depth 4).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axis_mux_inject;

   localparam int NCH   = 4;
   localparam int DW    = 128;
   localparam int TIDW  = 2;
   localparam int TDW   = 4;
   localparam int DSTW  = 6;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic [3:0]    gap;
   } beat_t;

   typedef struct packed {
      logic [DW-1:0]   data;
      logic [DSTW-1:0] dest;
      logic            tail;
   } flit_t;

   logic                      clk_noc = 1'b0;
   logic                      rst_noc_sync = 1'b1;
   logic [NCH-1:0]            tvalid;
   logic [NCH-1:0]            tready;
   logic [NCH-1:0][DW-1:0]    tdata;
   logic [NCH-1:0]            tlast;
   logic [NCH-1:0][TIDW-1:0]  tid;
   logic [NCH-1:0][TDW-1:0]   tdest;
   logic [DW-1:0]             data_out;
   logic [DSTW-1:0]           dest_out;
   logic                      is_tail_out;
   logic                      send_out;
   logic                      credit_in;
`ifdef AXIS_MUX_INJECT_STATS_EN
   logic [NCH-1:0][31:0]      pkt_count;
`endif

   logic credit_auto   = 1'b0;
   logic credit_auto_q = 1'b0;
   logic credit_man    = 1'b0;
   assign credit_in = credit_auto_q | credit_man;

   beat_t src_q [NCH][$];
   flit_t exp_q [$];
   int    send_cyc [$];
   int    checks   = 0;
   int    failures = 0;
   int    n_sends  = 0;
   int    cyc      = 0;

   always #5 clk_noc = ~clk_noc;
   always @(posedge clk_noc) cyc <= cyc + 1;

   axis_mux_inject #(
      .NUM_CHANNELS      (NCH),
      .TDATA_WIDTH       (DW),
      .TID_WIDTH         (TIDW),
      .TDEST_WIDTH       (TDW),
      .DEST_WIDTH        (DSTW),
      .FLIT_BUFFER_DEPTH (DEPTH)
   ) dut (
      .clk_noc        (clk_noc),
      .rst_noc_sync   (rst_noc_sync),
      .axis_in_tvalid (tvalid),
      .axis_in_tready (tready),
      .axis_in_tdata  (tdata),
      .axis_in_tlast  (tlast),
      .axis_in_tid    (tid),
      .axis_in_tdest  (tdest),
      .data_out       (data_out),
      .dest_out       (dest_out),
      .is_tail_out    (is_tail_out),
      .send_out       (send_out),
`ifdef AXIS_MUX_INJECT_STATS_EN
      .pkt_count      (pkt_count),
`endif
      .credit_in      (credit_in)
   );

   function automatic logic [DW-1:0] mkdata(input int ch, input int n);
      return {32'hFEED0000 + 32'(ch), 32'(n), 64'h0123_4567_89AB_CDEF ^ {32'(n), 32'(ch)}};
   endfunction

   // Hand-computed {tid, tdest} per channel
   function automatic logic [DSTW-1:0] exp_dest(input int ch);
      case (ch)
         0:       return 6'h1A;
         1:       return 6'h35;
         2:       return 6'h0C;
         default: return 6'h23;
      endcase
   endfunction

   function automatic bit src_busy();
      for (int c = 0; c < NCH; c++) begin
         if (src_q[c].size() != 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic push_beat(input int ch, input int n, input logic last, input int gap);
      beat_t b;
      b.data = mkdata(ch, n);
      b.last = last;
      b.gap  = 4'(gap);
      src_q[ch].push_back(b);
   endtask

   task automatic push_exp(input int ch, input int n, input logic last);
      flit_t f;
      f.data = mkdata(ch, n);
      f.dest = exp_dest(ch);
      f.tail = last;
      exp_q.push_back(f);
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || src_busy()) && t < 300) begin
         @(negedge clk_noc);
         t++;
      end
      checks++;
      if (t >= 300) begin
         failures++;
         $display("FAIL %s_timeout actual=%0d pending required=0", name, exp_q.size());
      end
      repeat (3) @(negedge clk_noc);
   endtask

   task automatic do_reset();
      @(negedge clk_noc);
      rst_noc_sync = 1'b1;
      for (int c = 0; c < NCH; c++) src_q[c].delete();
      repeat (2) @(negedge clk_noc);
      rst_noc_sync = 1'b0;
   endtask

   task automatic credit_pulses(input int n);
      credit_man = 1'b1;
      repeat (n) @(negedge clk_noc);
      credit_man = 1'b0;
   endtask

   // Source driver: presents queued beats, pops on handshake
   initial begin : drv
      logic [NCH-1:0] hs;
      int             gap_cnt [NCH];
      tvalid = '0;
      tlast  = '0;
      tdata  = '0;
      for (int c = 0; c < NCH; c++) gap_cnt[c] = 0;
      forever begin
         @(negedge clk_noc);
         hs = tvalid & tready;
         @(posedge clk_noc);
         #1;
         for (int c = 0; c < NCH; c++) begin
            if (hs[c] && src_q[c].size() > 0) begin
               void'(src_q[c].pop_front());
               gap_cnt[c] = 0;
            end
            if (src_q[c].size() == 0) begin
               tvalid[c]  = 1'b0;
               gap_cnt[c] = 0;
            end else if (gap_cnt[c] < int'(src_q[c][0].gap)) begin
               gap_cnt[c]++;
               tvalid[c] = 1'b0;
            end else begin
               tvalid[c] = 1'b1;
               tdata[c]  = src_q[c][0].data;
               tlast[c]  = src_q[c][0].last;
            end
         end
      end
   end

   // Monitor: scoreboard compare on every send_out, router credit return
   initial begin : mon
      flit_t e;
      forever begin
         @(negedge clk_noc);
         credit_auto_q = credit_auto && send_out;
         if (send_out) begin
            n_sends++;
            send_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_flit actual data=%h dest=%h tail=%b required none",
                        data_out, dest_out, is_tail_out);
            end else begin
               e = exp_q.pop_front();
               if (data_out !== e.data || dest_out !== e.dest || is_tail_out !== e.tail) begin
                  failures++;
                  $display("FAIL flit actual data=%h dest=%h tail=%b required data=%h dest=%h tail=%b",
                           data_out, dest_out, is_tail_out, e.data, e.dest, e.tail);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int start;
      int base;
      int t;
      tid   = {2'd2, 2'd0, 2'd3, 2'd1};
      tdest = {4'h3, 4'hC, 4'h5, 4'hA};

      // Reset values
      repeat (3) @(negedge clk_noc);
      check("rst_send",   128'(send_out),    128'd0);
      check("rst_tail",   128'(is_tail_out), 128'd0);
      check("rst_data",   128'(data_out),    128'd0);
      check("rst_dest",   128'(dest_out),    128'd0);
      check("rst_tready", 128'(tready),      128'd0);
      rst_noc_sync = 1'b0;
      @(negedge clk_noc);

      // Credit exhaustion
      start = n_sends;
      for (int n = 0; n < 6; n++) push_beat(0, n, 1'b1, 0);
      for (int n = 0; n < 4; n++) push_exp(0, n, 1'b1);
      repeat (20) @(negedge clk_noc);
      check("t1_sends_no_credit", 128'(n_sends - start), 128'd4);
      check("t1_blocked", 128'({tvalid[0], tready[0]}), 128'b10);
      push_exp(0, 4, 1'b1);
      credit_pulses(1);
      repeat (10) @(negedge clk_noc);
      check("t1_one_credit", 128'(n_sends - start), 128'd5);
      check("t1_blocked_again", 128'({tvalid[0], tready[0]}), 128'b10);
      push_exp(0, 5, 1'b1);
      credit_pulses(5);
      wait_idle("t1");
      check("t1_total", 128'(n_sends - start), 128'd6);
      credit_auto = 1'b1;

      // Round-robin over single-flit packets
      do_reset();
      push_beat(0, 10, 1'b1, 0);
      push_beat(0, 11, 1'b1, 0);
      for (int c = 1; c < NCH; c++) push_beat(c, 10, 1'b1, 0);
      push_exp(0, 10, 1'b1);
      push_exp(1, 10, 1'b1);
      push_exp(2, 10, 1'b1);
      push_exp(3, 10, 1'b1);
      push_exp(0, 11, 1'b1);
      base = send_cyc.size();
      wait_idle("t2");
      check("t2_full_rate", 128'(send_cyc[base+4] - send_cyc[base]), 128'd4);

      // Wormhole lock
      do_reset();
      push_beat(1, 20, 1'b0, 0);
      push_beat(1, 21, 1'b0, 0);
      push_beat(1, 22, 1'b1, 0);
      push_beat(2, 20, 1'b1, 0);
      push_exp(1, 20, 1'b0);
      push_exp(1, 21, 1'b0);
      push_exp(1, 22, 1'b1);
      push_exp(2, 20, 1'b1);
      base = send_cyc.size();
      @(negedge clk_noc);
      check("t3_grant_head", 128'(tready), 128'b0010);
      @(negedge clk_noc);
      check("t3_grant_locked", 128'(tready), 128'b0010);
      wait_idle("t3");
      check("t3_body_rate", 128'(send_cyc[base+2] - send_cyc[base]), 128'd2);
      check("t3_follow", 128'(send_cyc[base+3] - send_cyc[base+2]), 128'd1);

      // Owner bubble while another channel waits
      do_reset();
      push_beat(0, 30, 1'b0, 0);
      push_beat(0, 31, 1'b0, 0);
      push_beat(0, 32, 1'b0, 2);
      push_beat(0, 33, 1'b1, 0);
      push_beat(3, 30, 1'b1, 0);
      push_exp(0, 30, 1'b0);
      push_exp(0, 31, 1'b0);
      push_exp(0, 32, 1'b0);
      push_exp(0, 33, 1'b1);
      push_exp(3, 30, 1'b1);
      base = send_cyc.size();
      wait_idle("t4");
      check("t4_bubble", 128'(send_cyc[base+2] - send_cyc[base+1]), 128'd3);
      check("t4_follow", 128'(send_cyc[base+4] - send_cyc[base+3]), 128'd1);

      // Reset mid-packet
      do_reset();
      credit_auto = 1'b0;
      for (int n = 40; n < 44; n++) push_beat(1, n, (n == 43), 0);
      push_exp(1, 40, 1'b0);
      t = 0;
      while (!send_out && t < 50) begin
         @(negedge clk_noc);
         t++;
      end
      check("t5_first_flit", 128'(send_out), 128'd1);
      rst_noc_sync = 1'b1;
      src_q[1].delete();
      @(negedge clk_noc);
      check("t5_send_after_rst", 128'(send_out), 128'd0);
      check("t5_data_after_rst", 128'(data_out), 128'd0);
      rst_noc_sync = 1'b0;
      start = n_sends;
      for (int n = 50; n < 55; n++) push_beat(2, n, 1'b1, 0);
      for (int n = 50; n < 54; n++) push_exp(2, n, 1'b1);
      @(negedge clk_noc);
      check("t5_grant_new", 128'(tready), 128'b0100);
      repeat (20) @(negedge clk_noc);
      check("t5_credits_restored", 128'(n_sends - start), 128'd4);
      push_exp(2, 54, 1'b1);
      credit_pulses(5);
      wait_idle("t5");
      credit_auto = 1'b1;

      // Mixed traffic on channels 1 and 3 (packet counters when enabled)
      do_reset();
      for (int n = 60; n < 65; n++) push_beat(1, n, 1'b1, 0);
      push_beat(3, 60, 1'b0, 0);
      push_beat(3, 61, 1'b1, 0);
      push_beat(3, 62, 1'b0, 0);
      push_beat(3, 63, 1'b1, 0);
      push_exp(1, 60, 1'b1);
      push_exp(3, 60, 1'b0);
      push_exp(3, 61, 1'b1);
      push_exp(1, 61, 1'b1);
      push_exp(3, 62, 1'b0);
      push_exp(3, 63, 1'b1);
      push_exp(1, 62, 1'b1);
      push_exp(1, 63, 1'b1);
      push_exp(1, 64, 1'b1);
      wait_idle("t6");
`ifdef AXIS_MUX_INJECT_STATS_EN
      check("t6_cnt0", 128'(pkt_count[0]), 128'd0);
      check("t6_cnt1", 128'(pkt_count[1]), 128'd5);
      check("t6_cnt2", 128'(pkt_count[2]), 128'd0);
      check("t6_cnt3", 128'(pkt_count[3]), 128'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
